// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Write-back arbiter and busy scoreboard feeding the single register-file
//   write port. Single-cycle pipeline results take priority. Long-latency
//   results (div / load-miss) queue in a small FIFO and drain whenever the
//   pipeline leaves the port free. A starvation counter raises stall_req so
//   that the FIFO head is not held off indefinitely.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   pipe_we/waddr/wdata       pipeline result (always accepted)
//   lu_issue, lu_issue_addr   long-latency issue; marks destination busy
//   lu_valid/waddr/wdata      long-latency result, accepted when lu_ready
//   lu_ready                  FIFO not full (no pop-through)
//   chk_addr1/2 -> busy1/2    combinational scoreboard lookup (x0 never busy)
//   stall_req                 registered request to hold pipe_we low
//   fifo_cnt                  FIFO occupancy
//   we/waddr/wdata            registered register-file write port
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_we,
    input  logic [4:0]                    pipe_waddr,
    input  logic [31:0]                   pipe_wdata,
    input  logic                          lu_issue,
    input  logic [4:0]                    lu_issue_addr,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [4:0]                    lu_waddr,
    input  logic [31:0]                   lu_wdata,
    input  logic [4:0]                    chk_addr1,
    input  logic [4:0]                    chk_addr2,
    output logic                          busy1,
    output logic                          busy2,
    output logic                          stall_req,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          we,
    output logic [4:0]                    waddr,
    output logic [31:0]                   wdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [4:0]       fifo_addr_mem [FIFO_DEPTH];
    logic [31:0]      fifo_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      busy_q, busy_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             we_q, we_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             fifo_empty;
    logic             push;
    logic             pipe_sel;
    logic             pop;
    logic [4:0]       head_addr;
    logic [31:0]      head_data;

    // Saturating increment keeps the starvation count pinned at STARVE_MAX
    // should the head stay blocked past the stall request.
    function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
        if (v == STV_W'(STARVE_MAX)) begin
            return v;
        end
        return v + STV_W'(1);
    endfunction

    // Stage 0: arbitration between pipeline result and FIFO head
    always_comb begin
        fifo_empty = (cnt_q == '0);
        // Full means not ready even if the head pops this cycle.
        lu_ready   = (cnt_q != CNT_W'(FIFO_DEPTH));
        push       = lu_valid && lu_ready;
        // A pipeline write to x0 carries nothing and must not block the FIFO.
        pipe_sel   = pipe_we && (pipe_waddr != 5'd0);
        pop        = !pipe_sel && !fifo_empty;
        head_addr  = fifo_addr_mem[rptr_q];
        head_data  = fifo_data_mem[rptr_q];
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        we_d    = pipe_sel || pop;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pipe_sel) begin
            waddr_d = pipe_waddr;
            wdata_d = pipe_wdata;
        end else if (pop) begin
            waddr_d = head_addr;
            wdata_d = head_data;
        end

        // Clear first so that a same-cycle re-issue of the address wins.
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_addr] = 1'b0;
        end
        if (lu_issue && (lu_issue_addr != 5'd0)) begin
            busy_d[lu_issue_addr] = 1'b1;
        end

        if (pop || fifo_empty) begin
            starve_d = '0;
        end else begin
            starve_d = sat_inc(starve_q);
        end
        stall_d = (starve_d == STV_W'(STARVE_MAX));
    end

    // Stage 1: registered write port, FIFO control and scoreboard
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO storage is data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wptr_q] <= lu_waddr;
            fifo_data_mem[wptr_q] <= lu_wdata;
        end
    end

    assign busy1     = (chk_addr1 != 5'd0) && busy_q[chk_addr1];
    assign busy2     = (chk_addr2 != 5'd0) && busy_q[chk_addr2];
    assign stall_req = stall_q;
    assign fifo_cnt  = cnt_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed scenarios followed by randomized traffic, all compared each
//   cycle against a queue-based reference model of the write-back arbiter.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_issue;
    logic [4:0]  lu_issue_addr;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        busy1;
    logic        busy2;
    logic        stall_req;
    logic [2:0]  fifo_cnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    wb_arbiter #(
        .FIFO_DEPTH(DEPTH),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_waddr   (pipe_waddr),
        .pipe_wdata   (pipe_wdata),
        .lu_issue     (lu_issue),
        .lu_issue_addr(lu_issue_addr),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_waddr     (lu_waddr),
        .lu_wdata     (lu_wdata),
        .chk_addr1    (chk_addr1),
        .chk_addr2    (chk_addr2),
        .busy1        (busy1),
        .busy2        (busy2),
        .stall_req    (stall_req),
        .fifo_cnt     (fifo_cnt),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the FIFO is a plain queue of {addr,data}, the
    // scoreboard a bit set, starvation the length of the current blocked run.
    logic [36:0] m_q[$];
    logic [31:0] m_busy;
    int          m_starve;
    logic        m_stall;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_valid = 1'b0;
    bit          allow_collide = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst           = 1'b1;
        pipe_we       = 1'b0;
        pipe_waddr    = '0;
        pipe_wdata    = '0;
        lu_issue      = 1'b0;
        lu_issue_addr = '0;
        lu_valid      = 1'b0;
        lu_waddr      = '0;
        lu_wdata      = '0;
        chk_addr1     = '0;
        chk_addr2     = '0;
    endtask

    // Compare DUT against model, then advance model and DUT by one edge.
    task automatic step();
        bit          psel;
        bit          pop;
        bit          push;
        bit          had_entries;
        logic [36:0] head;
        #1;
        if (m_valid) begin
            chk1("we", we, m_we);
            chk("waddr", 32'(waddr), 32'(m_waddr));
            chk("wdata", wdata, m_wdata);
            chk1("stall_req", stall_req, m_stall);
            chk("fifo_cnt", 32'(fifo_cnt), m_q.size());
            chk1("lu_ready", lu_ready, m_q.size() != DEPTH);
            chk1("busy1", busy1, (chk_addr1 != 5'd0) && m_busy[chk_addr1]);
            chk1("busy2", busy2, (chk_addr2 != 5'd0) && m_busy[chk_addr2]);
            if (rst) begin
                chk1("proto_pipe_we_in_stall", pipe_we & m_stall, 1'b0);
                if (!allow_collide) begin
                    chk1("proto_issue_busy",
                         lu_issue && (lu_issue_addr != 5'd0) && m_busy[lu_issue_addr], 1'b0);
                end
            end
        end

        if (!rst) begin
            m_q.delete();
            m_busy   = '0;
            m_starve = 0;
            m_stall  = 1'b0;
            m_we     = 1'b0;
            m_waddr  = '0;
            m_wdata  = '0;
            m_valid  = 1'b1;
        end else begin
            had_entries = (m_q.size() > 0);
            psel = pipe_we && (pipe_waddr != 5'd0);
            pop  = !psel && had_entries;
            push = lu_valid && (m_q.size() < DEPTH);
            head = '0;
            if (pop) head = m_q.pop_front();
            if (push) m_q.push_back({lu_waddr, lu_wdata});
            if (psel) begin
                m_we    = 1'b1;
                m_waddr = pipe_waddr;
                m_wdata = pipe_wdata;
            end else if (pop) begin
                m_we    = 1'b1;
                m_waddr = head[36:32];
                m_wdata = head[31:0];
                m_busy[head[36:32]] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (lu_issue && (lu_issue_addr != 5'd0)) m_busy[lu_issue_addr] = 1'b1;
            if (pop || !had_entries) m_starve = 0;
            else if (m_starve < SMAX) m_starve++;
            m_stall = (m_starve >= SMAX);
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();

        // T1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            rst        = 1'b0;
            pipe_we    = 1'($urandom);
            pipe_waddr = 5'($urandom);
            pipe_wdata = $urandom;
            lu_issue   = 1'($urandom);
            lu_issue_addr = 5'($urandom);
            lu_valid   = 1'($urandom);
            lu_waddr   = 5'($urandom);
            lu_wdata   = $urandom;
            chk_addr1  = 5'($urandom);
            chk_addr2  = 5'($urandom);
            step();
        end
        idle();
        chk_addr1 = 5'd7;
        chk_addr2 = 5'd19;
        #1;
        chk1("t1_we", we, 1'b0);
        chk("t1_waddr", 32'(waddr), 32'd0);
        chk("t1_wdata", wdata, 32'd0);
        chk("t1_fifo_cnt", 32'(fifo_cnt), 32'd0);
        chk1("t1_stall", stall_req, 1'b0);
        chk1("t1_busy1", busy1, 1'b0);
        chk1("t1_busy2", busy2, 1'b0);

        // T2: pipeline path
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
        step();
        chk1("t2_we", we, 1'b1);
        chk("t2_waddr", 32'(waddr), 32'd5);
        chk("t2_wdata", wdata, 32'hDEADBEEF);
        pipe_waddr = 5'd0; pipe_wdata = 32'h1;
        step();
        chk1("t2_x0_we", we, 1'b0);
        chk("t2_x0_hold", wdata, 32'hDEADBEEF);
        pipe_we = 1'b0;

        // T3: long-latency path and scoreboard
        lu_issue = 1'b1; lu_issue_addr = 5'd7;
        step();
        lu_issue = 1'b0;
        chk_addr1 = 5'd7;
        #1;
        chk1("t3_busy_set", busy1, 1'b1);
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h12345678;
        step();
        lu_valid = 1'b0;
        chk1("t3_not_yet", we, 1'b0);
        chk("t3_cnt", 32'(fifo_cnt), 32'd1);
        step();
        chk1("t3_we", we, 1'b1);
        chk("t3_waddr", 32'(waddr), 32'd7);
        chk("t3_wdata", wdata, 32'h12345678);
        chk1("t3_busy_clr", busy1, 1'b0);

        // T4: fill under pipeline pressure, then drain in order
        pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h9;
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1'b1; lu_waddr = 5'(10 + i); lu_wdata = 32'hA000_0000 + 32'(i);
            step();
        end
        chk("t4_full_cnt", 32'(fifo_cnt), 32'd4);
        chk1("t4_not_ready", lu_ready, 1'b0);
        lu_waddr = 5'd14; lu_wdata = 32'hA000_0004;
        step();
        step();
        chk("t4_held_cnt", 32'(fifo_cnt), 32'd4);
        chk("t4_pipe_wins", 32'(waddr), 32'd9);
        pipe_we = 1'b0;
        step();
        chk("t4_drain0", wdata, 32'hA000_0000);
        chk("t4_no_popthru", 32'(fifo_cnt), 32'd3);
        for (int i = 1; i < 5; i++) begin
            step();
            lu_valid = 1'b0;
            chk("t4_drain", wdata, 32'hA000_0000 + 32'(i));
        end
        chk("t4_last_addr", 32'(waddr), 32'd14);
        chk("t4_empty", 32'(fifo_cnt), 32'd0);

        // T5: starvation
        pipe_we = 1'b1; pipe_waddr = 5'd9;
        lu_valid = 1'b1; lu_waddr = 5'd4; lu_wdata = 32'h55;
        step();
        lu_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) chk1("t5_no_stall_yet", stall_req, 1'b0);
        end
        chk1("t5_stall", stall_req, 1'b1);
        pipe_we = 1'b0;
        step();
        chk1("t5_pop_we", we, 1'b1);
        chk("t5_pop_data", wdata, 32'h55);
        chk1("t5_stall_clr", stall_req, 1'b0);

        // T6: set/clear collision, then reset with queued entries
        lu_issue = 1'b1; lu_issue_addr = 5'd3;
        step();
        lu_issue = 1'b0;
        lu_valid = 1'b1; lu_waddr = 5'd3; lu_wdata = 32'h33;
        step();
        lu_valid = 1'b0;
        allow_collide = 1'b1;
        lu_issue = 1'b1; lu_issue_addr = 5'd3; chk_addr1 = 5'd3;
        step();
        lu_issue = 1'b0;
        allow_collide = 1'b0;
        chk("t6_waddr", 32'(waddr), 32'd3);
        chk1("t6_busy_kept", busy1, 1'b1);
        pipe_we = 1'b1; pipe_waddr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            lu_valid = 1'b1; lu_waddr = 5'(20 + i); lu_wdata = 32'hC0 + 32'(i);
            step();
        end
        lu_valid = 1'b0; pipe_we = 1'b0;
        chk("t6_queued", 32'(fifo_cnt), 32'd3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_rst_cnt", 32'(fifo_cnt), 32'd0);
        chk1("t6_rst_busy", busy1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("t6_no_stale", we, 1'b0);
        end

        // Randomized traffic in phases of increasing pipeline pressure
        for (int c = 0; c < 3000; c++) begin
            int pp;
            int ph;
            ph = (c / 500) % 3;
            pp = (ph == 0) ? 30 : ((ph == 1) ? 70 : 96);
            rst           = ($urandom_range(0, 299) != 0);
            pipe_we       = !m_stall && ($urandom_range(0, 99) < pp);
            pipe_waddr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            pipe_wdata    = $urandom;
            lu_issue_addr = 5'($urandom);
            lu_issue      = ($urandom_range(0, 3) == 0) && !m_busy[lu_issue_addr];
            lu_valid      = 1'($urandom);
            lu_waddr      = 5'($urandom);
            lu_wdata      = $urandom;
            chk_addr1     = 5'($urandom);
            chk_addr2     = 5'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
